// File: rtl/vga_stream_checker_if.sv
// VGA raster stream bundle: pixel counters, sync/blank controls and colour.
interface vga_if;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hsync;
   logic        hblnk;
   logic        vsync;
   logic        vblnk;
   logic [11:0] rgb;

   modport in  (input  hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);
   modport out (output hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);
endinterface

// File: rtl/vga_stream_checker.sv
// Sink-side VGA stream checker: locks on the (0,0) origin sample, then verifies
// raster counter order and sync/blank timing, reporting sticky errors and frames.
module vga_stream_checker #(
   parameter int unsigned H_TOTAL      = 1056,
   parameter int unsigned V_TOTAL      = 628,
   parameter int unsigned H_ACTIVE     = 800,
   parameter int unsigned V_ACTIVE     = 600,
   parameter int unsigned H_SYNC_START = 840,
   parameter int unsigned H_SYNC_END   = 968,
   parameter int unsigned V_SYNC_START = 601,
   parameter int unsigned V_SYNC_END   = 605
) (
   input  logic        clk,
   input  logic        rst_n,
   vga_if.in           vga_in,
   input  logic        clr_err,
   output logic        locked,
   output logic        err_count,
   output logic [3:0]  err_sync,
   output logic [15:0] frame_cnt,
   output logic        frame_done
);

   localparam int unsigned CW = 11;
   localparam int unsigned FW = 16;

   localparam logic [0:0] SEARCH = 1'b0;
   localparam logic [0:0] LOCKED = 1'b1;

   logic [0:0]    state, state_nxt;
   logic [CW-1:0] eh, eh_nxt;
   logic [CW-1:0] ev, ev_nxt;
   logic          locked_nxt;
   logic          err_count_nxt;
   logic [3:0]    err_sync_nxt;
   logic [FW-1:0] frame_cnt_nxt;
   logic          frame_done_nxt;

   logic [CW-1:0] h, v;
   logic          origin_c;
   logic          line_end_c;
   logic [3:0]    sync_seen_c;
   logic [3:0]    sync_exp_c;
   logic          unused_rgb;

   assign h          = vga_in.hcount;
   assign v          = vga_in.vcount;
   assign origin_c   = (h == '0) && (v == '0);
   assign line_end_c = (h == CW'(H_TOTAL - 1));
   assign sync_seen_c = {vga_in.hsync, vga_in.hblnk, vga_in.vsync, vga_in.vblnk};
   assign sync_exp_c  = {(h >= CW'(H_SYNC_START)) && (h < CW'(H_SYNC_END)),
                         (h >= CW'(H_ACTIVE)),
                         (v >= CW'(V_SYNC_START)) && (v < CW'(V_SYNC_END)),
                         (v >= CW'(V_ACTIVE))};
   // rgb carries no timing information
   assign unused_rgb = ^vga_in.rgb;

   // State and result registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= SEARCH;
         eh         <= '0;
         ev         <= '0;
         locked     <= 1'b0;
         err_count  <= 1'b0;
         err_sync   <= 4'b0;
         frame_cnt  <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         eh         <= eh_nxt;
         ev         <= ev_nxt;
         locked     <= locked_nxt;
         err_count  <= err_count_nxt;
         err_sync   <= err_sync_nxt;
         frame_cnt  <= frame_cnt_nxt;
         frame_done <= frame_done_nxt;
      end
   end

   // Next state, expected raster position and flag updates
   always_comb begin
      state_nxt      = state;
      eh_nxt         = eh;
      ev_nxt         = ev;
      err_count_nxt  = clr_err ? 1'b0 : err_count;
      err_sync_nxt   = clr_err ? 4'b0 : err_sync;
      frame_cnt_nxt  = frame_cnt;
      frame_done_nxt = 1'b0;

      case (state)
         SEARCH: begin
            if (origin_c) begin
               state_nxt = LOCKED;
               eh_nxt    = CW'(1);
               ev_nxt    = '0;
            end
         end
         default: begin
            // Expected counters stay in range, so out-of-range samples fail here
            if ((h != eh) || (v != ev)) begin
               err_count_nxt = 1'b1;
               state_nxt     = SEARCH;
               eh_nxt        = '0;
               ev_nxt        = '0;
            end else begin
               eh_nxt       = line_end_c ? '0 : h + CW'(1);
               ev_nxt       = !line_end_c ? v :
                              (v == CW'(V_TOTAL - 1)) ? '0 : v + CW'(1);
               err_sync_nxt = err_sync_nxt | (sync_seen_c ^ sync_exp_c);
               if (origin_c) begin
                  frame_done_nxt = 1'b1;
                  frame_cnt_nxt  = frame_cnt + FW'(1);
               end
            end
         end
      endcase

      locked_nxt = (state_nxt == LOCKED);
   end

endmodule

// File: doc/vga_stream_checker.md
Name: vga_stream_checker

Overview:
- Sink-side checker for the VGA stream carried on vga_if; it connects to the in modport, at the output of any stage that drives the interface.
- Locks onto the frame by finding the origin sample (hcount=0, vcount=0).
- Checks that the counters advance in strict raster order, and that hsync/hblnk/vsync/vblnk agree with the configured timing.
- Reports lock state, sticky error flags and a frame counter; used in hardware bring-up and as a bench scoreboard.

Parameters:
H_TOTAL, 1056, pixels per line including blanking
V_TOTAL, 628, lines per frame including blanking
H_ACTIVE, 800, visible pixels; hblnk=1 when hcount>=H_ACTIVE
V_ACTIVE, 600, visible lines; vblnk=1 when vcount>=V_ACTIVE
H_SYNC_START, 840, first hcount with hsync=1
H_SYNC_END, 968, first hcount after the hsync pulse
V_SYNC_START, 601, first vcount with vsync=1
V_SYNC_END, 605, first vcount after the vsync pulse

Ports:
clk  input  1  pixel clock, the same clock that drives the stream
rst_n  input  1  synchronous reset, active low
vga_in  input  vga_if.in  monitored stream: hcount/vcount[10:0], hsync, hblnk, vsync, vblnk, rgb[11:0]; rgb is ignored
clr_err  input  1  one-cycle pulse that clears err_count and err_sync
locked  output  1  checker is tracking the raster
err_count  output  1  sticky flag: counter sequence broken
err_sync  output  4  sticky flags {hsync, hblnk, vsync, vblnk}: control signal mismatch
frame_cnt  output  16  completed frames since lock
frame_done  output  1  one-cycle pulse per completed frame

Behaviour:
- Clock and reset: one clock. Reset is synchronous, active-low, sampled on the rising edge of clk.
- Reset values: locked=0, err_count=0, err_sync=4'b0, frame_cnt=0, frame_done=0, state=SEARCH, expected counters=0.
- Reset asserted mid-frame: all outputs take their reset values at the next edge; the checker relocks only at the next (0,0).
- Sampling: all vga_in fields are sampled on every rising edge. Outputs are registered, so each result appears 1 cycle after the sample that caused it.
- Expected-next rule, applied every locked cycle:
  - eh = (h==H_TOTAL-1) ? 0 : h+1
  - ev = (h==H_TOTAL-1) ? ((v==V_TOTAL-1) ? 0 : v+1) : v
  - Arithmetic is 11-bit and never exceeds H_TOTAL-1 or V_TOTAL-1.
- State SEARCH:
  - locked=0.
  - A sample with h=0 and v=0 moves the FSM to LOCKED, sets locked=1 on the next cycle and loads eh=1, ev=0.
  - The lock sample does not count as a frame and does not pulse frame_done.
  - No checks run in SEARCH.
- State LOCKED, counter check:
  - The sample must equal (eh, ev).
  - On mismatch: set err_count, go to SEARCH, locked=0 next cycle, frame_done not asserted.
- State LOCKED, sync check (on matching samples):
  - Expected hsync = (h>=H_SYNC_START && h<H_SYNC_END).
  - Expected hblnk = (h>=H_ACTIVE).
  - Expected vsync = (v>=V_SYNC_START && v<V_SYNC_END).
  - Expected vblnk = (v>=V_ACTIVE).
  - A mismatch sets the matching err_sync bit (bit3=hsync, bit2=hblnk, bit1=vsync, bit0=vblnk). The checker stays locked.
- Frame completion:
  - A matching sample (0,0) while LOCKED completes a frame.
  - frame_done=1 for exactly 1 cycle and frame_cnt increments.
  - frame_cnt wraps from 16'hFFFF to 0 with no flag.
  - frame_cnt holds its value in SEARCH and is cleared only by reset.
- clr_err:
  - Clears err_count and err_sync on the next edge.
  - If a new error is detected on the same edge, the new error's bit is set (set wins over clear); other bits clear.
  - clr_err does not affect locked or frame_cnt.
- Counter mismatch and sync mismatch on the same sample: only err_count is set. Sync checks are skipped for samples that fail the counter check.
- Out-of-range counters (h>=H_TOTAL or v>=V_TOTAL) while LOCKED are a counter mismatch. In SEARCH they are ignored.

Test Plan:
- Nominal stream from a conforming generator, starting at (500,300), 3 full frames:
  - locked rises 1 cycle after (0,0) is sampled.
  - frame_done pulses 3 times, spaced 663168 cycles apart.
  - frame_cnt=3; err_count=0; err_sync=4'b0000.
- Skip: hcount jumps 100→102 in line 10:
  - err_count=1 and locked=0 one cycle after the 102 sample.
  - Relock at the next (0,0); frame_cnt unchanged by the relock.
- hsync held low at hcount=900 of one line: err_sync=4'b1000, locked stays 1, err_count=0.
- Flip vblnk at v=599 and pulse clr_err on that same sample's result edge:
  - err_sync=4'b0001 after that edge.
  - A further clr_err pulse with no new error clears it to 4'b0000.
- rst_n=0 for 1 cycle mid-frame after 2 frames: all outputs return to 0; the next (0,0) relocks with frame_cnt starting from 0.
- frame_cnt forced to 16'hFFFF via hierarchical deposit, then one frame completes: frame_cnt=0, frame_done=1 for that one cycle.
